sram_port_arbiter: RTL and testbench

- Arbitrates the single-port SRAM among three requesters: serial loader (SRAM_IO_CTRL), SPI streaming engine and SERIAL_CPU_8BIT.
- Replaces the current combinational priority mux with a registered grant FSM. Adds a turnaround cycle, a burst limit, read-data valid tagging and a CPU stall output.
- Sits between the requesters and the SRAM macro pins (CEN/WEN/A/D/Q).

---
 rtl/sram_port_arbiter_pkg.sv | 15 +
 rtl/sram_arb_pick.sv | 14 +
 rtl/sram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: grant states, owner tags and round-robin codes shared by the arbiter
package sram_port_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LD   = 2'd1,
        ST_SPI  = 2'd2,
        ST_CPU  = 2'd3
    } st_t;
    localparam int N_OWN   = 3;
    localparam int OWN_LD  = 0;
    localparam int OWN_SPI = 1;
    localparam int OWN_CPU = 2;
    localparam logic RR_SPI = 1'b0;
    localparam logic RR_CPU = 1'b1;
endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: loader-first selector with SPI/CPU round-robin, used only from IDLE
module sram_arb_pick
    import sram_port_arbiter_pkg::*;
(
    input  logic i_ld,
    input  logic i_spi,
    input  logic i_cpu,
    input  logic i_rr,
    output st_t  o_win
);
    assign o_win = i_ld                             ? ST_LD  :
                   (i_spi && (!i_cpu || i_rr == RR_SPI)) ? ST_SPI :
                   i_cpu                            ? ST_CPU : ST_IDLE;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: registered grant FSM muxing loader, SPI and CPU onto one SRAM port
// with a turnaround IDLE cycle between owners, an SPI/CPU burst limit and tagged read-valid.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ld_req,
    input  logic                  spi_req,
    input  logic                  cpu_req,
    input  logic                  ld_cen,
    input  logic                  spi_cen,
    input  logic                  cpu_cen,
    input  logic                  ld_wen,
    input  logic                  spi_wen,
    input  logic                  cpu_wen,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [ADDR_WIDTH-1:0] spi_addr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] ld_din,
    input  logic [DATA_WIDTH-1:0] spi_din,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic                  ld_gnt,
    output logic                  spi_gnt,
    output logic                  cpu_gnt,
    output logic                  ld_rvld,
    output logic                  spi_rvld,
    output logic                  cpu_rvld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  cpu_stall,
    output logic                  CEN_after_mux,
    output logic                  WEN_after_mux,
    output logic [ADDR_WIDTH-1:0] A_after_mux,
    output logic [DATA_WIDTH-1:0] D_after_mux,
    input  logic [DATA_WIDTH-1:0] Q_from_SRAM
);
    st_t                  r_state;
    st_t                  w_next;
    st_t                  w_pick;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_rr;
    logic [N_OWN-1:0]     r_rvld;
    logic [N_OWN-1:0]     w_own;
    logic                 w_cnt_max;
    logic                 w_rd;

    sram_arb_pick u_pick (
        .i_ld  (ld_req),
        .i_spi (spi_req),
        .i_cpu (cpu_req),
        .i_rr  (r_rr),
        .o_win (w_pick)
    );

    assign w_cnt_max = r_cnt == CNT_WIDTH'(MAX_BURST - 1);

    // Owners only ever return to IDLE, so every hand-over costs one deselected cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_pick;
            ST_LD:   w_next = ld_req ? ST_LD : ST_IDLE;
            ST_SPI:  w_next = (!spi_req || (w_cnt_max && (ld_req || cpu_req))) ? ST_IDLE : ST_SPI;
            ST_CPU:  w_next = (!cpu_req || (w_cnt_max && (ld_req || spi_req))) ? ST_IDLE : ST_CPU;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        CEN_after_mux = 1'b1;
        WEN_after_mux = 1'b1;
        A_after_mux   = '0;
        D_after_mux   = '0;
        case (r_state)
            ST_LD: begin
                CEN_after_mux = ld_cen;
                WEN_after_mux = ld_wen;
                A_after_mux   = ld_addr;
                D_after_mux   = ld_din;
            end
            ST_SPI: begin
                CEN_after_mux = spi_cen;
                WEN_after_mux = spi_wen;
                A_after_mux   = spi_addr;
                D_after_mux   = spi_din;
            end
            ST_CPU: begin
                CEN_after_mux = cpu_cen;
                WEN_after_mux = cpu_wen;
                A_after_mux   = cpu_addr;
                D_after_mux   = cpu_din;
            end
            default: ;
        endcase
    end

    assign w_own[OWN_LD]  = r_state == ST_LD;
    assign w_own[OWN_SPI] = r_state == ST_SPI;
    assign w_own[OWN_CPU] = r_state == ST_CPU;
    assign w_rd           = !CEN_after_mux && WEN_after_mux;

    // The counter is cleared in IDLE, which every grant entry passes through; it saturates at the limit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rr    <= RR_SPI;
            r_rvld  <= '0;
        end else begin
            r_state <= w_next;
            r_rvld  <= w_rd ? w_own : '0;
            if (r_state == ST_IDLE)
                r_cnt <= '0;
            else if (r_state != ST_LD && !w_cnt_max)
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (r_state == ST_IDLE && w_next == ST_SPI)
                r_rr <= RR_CPU;
            else if (r_state == ST_IDLE && w_next == ST_CPU)
                r_rr <= RR_SPI;
        end
    end

    assign ld_gnt    = w_own[OWN_LD];
    assign spi_gnt   = w_own[OWN_SPI];
    assign cpu_gnt   = w_own[OWN_CPU];
    assign ld_rvld   = r_rvld[OWN_LD];
    assign spi_rvld  = r_rvld[OWN_SPI];
    assign cpu_rvld  = r_rvld[OWN_CPU];
    assign rd_data   = Q_from_SRAM;
    assign cpu_stall = cpu_req && !cpu_gnt;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios plus random traffic checked against an owner/burst-length model
// and a behavioural SRAM attached to the arbiter pins.
module tb_sram_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int MB = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [2:0]    req = '0;
    logic [2:0]    cen = '1;
    logic [2:0]    wen = '1;
    logic [AW-1:0] addr [3];
    logic [DW-1:0] din [3];
    logic          ld_gnt, spi_gnt, cpu_gnt, ld_rvld, spi_rvld, cpu_rvld, cpu_stall;
    logic          CEN_after_mux, WEN_after_mux;
    logic [AW-1:0] A_after_mux;
    logic [DW-1:0] D_after_mux, rd_data, q;

    int n_chk = 0;
    int n_err = 0;

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(5)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ld_req(req[0]), .spi_req(req[1]), .cpu_req(req[2]),
        .ld_cen(cen[0]), .spi_cen(cen[1]), .cpu_cen(cen[2]),
        .ld_wen(wen[0]), .spi_wen(wen[1]), .cpu_wen(wen[2]),
        .ld_addr(addr[0]), .spi_addr(addr[1]), .cpu_addr(addr[2]),
        .ld_din(din[0]), .spi_din(din[1]), .cpu_din(din[2]),
        .ld_gnt(ld_gnt), .spi_gnt(spi_gnt), .cpu_gnt(cpu_gnt),
        .ld_rvld(ld_rvld), .spi_rvld(spi_rvld), .cpu_rvld(cpu_rvld),
        .rd_data(rd_data), .cpu_stall(cpu_stall),
        .CEN_after_mux(CEN_after_mux), .WEN_after_mux(WEN_after_mux),
        .A_after_mux(A_after_mux), .D_after_mux(D_after_mux),
        .Q_from_SRAM(q)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] dflt(int i);
        return (i == 5) ? 8'hA7 : DW'(i * 37 + 11);
    endfunction

    // behavioural SRAM on the arbiter pins
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          mem_init = 1'b1;
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= dflt(i);
            mem_init <= 1'b0;
        end else if (!CEN_after_mux) begin
            if (WEN_after_mux) q <= mem[A_after_mux];
            else mem[A_after_mux] <= D_after_mux;
        end
    end

    // reference model: owner index (-1 none, 0 ld, 1 spi, 2 cpu), cycles held, rr winner, own memory image
    int            m_own = -1;
    int            m_len = 0;
    int            m_rr = 1;
    int            m_rv = -1;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] mm [0:(1<<AW)-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int o;
        o = m_own < 0 ? 0 : m_own;
        chk("gnt", 32'({cpu_gnt, spi_gnt, ld_gnt}), m_own < 0 ? 0 : 32'(1) << m_own);
        chk("rvld", 32'({cpu_rvld, spi_rvld, ld_rvld}), m_rv < 0 ? 0 : 32'(1) << m_rv);
        if (m_rv >= 0) chk("rd_data", 32'(rd_data), 32'(m_rd));
        chk("stall", 32'(cpu_stall), 32'(req[2] && m_own != 2));
        chk("cen", 32'(CEN_after_mux), m_own < 0 ? 1 : 32'(cen[o]));
        chk("wen", 32'(WEN_after_mux), m_own < 0 ? 1 : 32'(wen[o]));
        chk("addr", 32'(A_after_mux), m_own < 0 ? 0 : 32'(addr[o]));
        chk("din", 32'(D_after_mux), m_own < 0 ? 0 : 32'(din[o]));
    endtask

    task automatic step();
        int rv;
        int nxt;
        @(posedge CLK);
        rv = -1;
        if (m_own >= 0 && !cen[m_own]) begin
            if (wen[m_own]) begin
                rv = m_own;
                m_rd = mm[addr[m_own]];
            end else mm[addr[m_own]] = din[m_own];
        end
        nxt = m_own;
        if (m_own < 0) begin
            if (req[0]) nxt = 0;
            else if (req[1] && req[2]) nxt = m_rr;
            else if (req[1]) nxt = 1;
            else if (req[2]) nxt = 2;
            if (nxt > 0) m_rr = 3 - nxt;
            m_len = 1;
        end else if (!req[m_own]) nxt = -1;
        else if (m_own > 0 && m_len >= MB && (req[0] || req[3 - m_own])) nxt = -1;
        else m_len++;
        m_own = nxt;
        m_rv = rv;
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic do_reset();
        #2 RST_N = 1'b0;
        #1;
        chk("rst_gnt", 32'({cpu_gnt, spi_gnt, ld_gnt}), 0);
        chk("rst_rvld", 32'({cpu_rvld, spi_rvld, ld_rvld}), 0);
        chk("rst_cen", 32'(CEN_after_mux), 1);
        chk("rst_wen", 32'(WEN_after_mux), 1);
        chk("rst_addr", 32'(A_after_mux), 0);
        chk("rst_din", 32'(D_after_mux), 0);
        m_own = -1;
        m_len = 0;
        m_rr = 1;
        m_rv = -1;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic idle_all();
        req = '0;
        cen = '1;
        wen = '1;
        step();
        step();
    endtask

    initial begin
        int n_a;
        int n_b;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            din[i] = '0;
        end
        for (int i = 0; i < (1 << AW); i++) mm[i] = dflt(i);
        do_reset();

        // cpu read of address 5
        req = 3'b100;
        cen[2] = 1'b0;
        addr[2] = 9'h005;
        step();
        chk("t1_gnt", 32'(cpu_gnt), 1);
        step();
        chk("t1_rvld", 32'(cpu_rvld), 1);
        chk("t1_q", 32'(rd_data), 32'h A7);
        idle_all();

        // spi/cpu contest: spi first for a full burst, one IDLE, then cpu
        req = 3'b110;
        n_a = 0;
        n_b = 0;
        for (int i = 0; i < 40 && !cpu_gnt; i++) begin
            step();
            if (spi_gnt) n_a++;
            else if (!cpu_gnt) n_b++;
        end
        chk("t2_spi_len", 32'(n_a), 16);
        chk("t2_gap", 32'(n_b), 1);
        chk("t2_cpu", 32'(cpu_gnt), 1);
        idle_all();

        // loader arrives mid cpu burst and waits for the burst limit
        req = 3'b100;
        step();
        step();
        req = 3'b101;
        n_a = 2;
        for (int i = 0; i < 40 && !ld_gnt; i++) begin
            step();
            if (cpu_gnt) n_a++;
        end
        chk("t3_cpu_len", 32'(n_a), 16);
        chk("t3_ld", 32'(ld_gnt), 1);
        req = 3'b011;
        n_a = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ld_gnt) n_a++;
        end
        chk("t3_ld_len", 32'(n_a), 40);

        // loader write to the top address, then read it back
        cen[0] = 1'b0;
        wen[0] = 1'b0;
        addr[0] = 9'h1FF;
        din[0] = 8'h3C;
        step();
        chk("t4_wen", 32'(WEN_after_mux), 0);
        chk("t4_a", 32'(A_after_mux), 32'h1FF);
        chk("t4_d", 32'(D_after_mux), 32'h3C);
        cen[0] = 1'b1;
        wen[0] = 1'b1;
        step();
        chk("t4_norvld", 32'({cpu_rvld, spi_rvld, ld_rvld}), 0);
        cen[0] = 1'b0;
        step();
        chk("t4_rvld", 32'(ld_rvld), 1);
        chk("t4_q", 32'(rd_data), 32'h3C);
        idle_all();

        // lone spi never gets a forced release
        req = 3'b010;
        step();
        n_a = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (spi_gnt) n_a++;
        end
        chk("t5_spi_len", 32'(n_a), 30);
        idle_all();

        // reset while a cpu read is returning
        req = 3'b100;
        cen[2] = 1'b0;
        addr[2] = 9'h005;
        step();
        step();
        chk("t6_rvld_pre", 32'(cpu_rvld), 1);
        do_reset();
        chk("t6_stall", 32'(cpu_stall), 1);
        cen[2] = 1'b1;
        req = 3'b110;
        step();
        chk("t6_rr", 32'(spi_gnt), 1);
        idle_all();

        // random traffic over a small address window so reads hit earlier writes
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(p == 0 ? 39 : 19, 0) == 0) req[p] = ~req[p];
                cen[p] = 1'($urandom_range(1, 0));
                wen[p] = 1'($urandom_range(1, 0));
                addr[p] = AW'($urandom_range(15, 0));
                din[p] = DW'($urandom);
            end
            if (c == 1000) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
